// File: rtl/panel_bus_master_pkg.sv
// Shared definitions for the front-panel bus master: FSM state encoding,
// default timing constants and the captured request record.
package panel_bus_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STALL   = 3'd1,
    ST_ABORT   = 3'd2,
    ST_ISOLATE = 3'd3,
    ST_SETUP   = 3'd4,
    ST_STROBE  = 3'd5,
    ST_DONE    = 3'd6,
    ST_RELEASE = 3'd7
  } state_t;

  localparam int GUARD_CYC_DEF    = 4;
  localparam int SETUP_CYC_DEF    = 2;
  localparam int STROBE_CYC_DEF   = 6;
  localparam int HALT_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } req_t;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // One spare bit above $clog2 so the largest load value always fits.
  function automatic int timer_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/panel_bus_master_cycle_timer.sv
// Loadable down-counter shared by every timed wait of the bus master.
// Saturates at zero; done is high whenever the count is zero.
module panel_bus_master_cycle_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/panel_bus_master.sv
// Arbitrates the shared RAM bus between the 6502 and front-panel
// examine/deposit requests: stall CPU, isolate it, run RAM cycles, hand back.
module panel_bus_master
  import panel_bus_master_pkg::*;
#(
  parameter int GUARD_CYC    = GUARD_CYC_DEF,
  parameter int SETUP_CYC    = SETUP_CYC_DEF,
  parameter int STROBE_CYC   = STROBE_CYC_DEF,
  parameter int HALT_TIMEOUT = HALT_TIMEOUT_DEF
) (
  input  logic        clk,
  input  logic        rst_p,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_err,
  input  logic        phi2_rise,
  input  logic        phi2_fall,
  input  logic        cpu_rw,
  output logic        cpu_rdy,
  output logic        drive_bus_n,
  output logic        phys_bus_en_n,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_doe,
  output logic        bus_rw,
  input  logic [7:0]  bus_din,
  output logic        ram_cs_n,
  output logic        busy
);

  localparam int TW = timer_width(max4(GUARD_CYC, SETUP_CYC, STROBE_CYC, HALT_TIMEOUT));

  // Waits are loaded with N-1 so the state lasts exactly N cycles.
  localparam logic [TW-1:0] HALT_LD   = TW'(HALT_TIMEOUT);
  localparam logic [TW-1:0] GUARD_LD  = TW'(GUARD_CYC - 1);
  localparam logic [TW-1:0] SETUP_LD  = TW'(SETUP_CYC - 1);
  localparam logic [TW-1:0] STROBE_LD = TW'(STROBE_CYC - 1);

  state_t         state;
  req_t           cur_req;
  logic           tmr_load;
  logic           tmr_dec;
  logic [TW-1:0]  tmr_val;
  logic           tmr_done;

  panel_bus_master_cycle_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst_p),
    .load     (tmr_load),
    .dec      (tmr_dec),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer is reloaded on the same edge that enters the next timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          tmr_load = 1'b1;
          tmr_val  = HALT_LD;
        end
      end
      ST_STALL: begin
        if (phi2_fall && cpu_rw) begin
          tmr_load = 1'b1;
          tmr_val  = GUARD_LD;
        end else begin
          tmr_dec = phi2_rise;
        end
      end
      ST_ISOLATE: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          tmr_val  = STROBE_LD;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_STROBE: begin
        tmr_dec = !tmr_done;
      end
      ST_DONE: begin
        tmr_load = 1'b1;
        tmr_val  = req_valid ? SETUP_LD : GUARD_LD;
      end
      ST_RELEASE: begin
        tmr_dec = 1'b1;
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      state         <= ST_IDLE;
      cur_req       <= '0;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_err       <= 1'b0;
      rsp_rdata     <= 8'h00;
      cpu_rdy       <= 1'b1;
      drive_bus_n   <= 1'b1;
      phys_bus_en_n <= 1'b0;
      bus_addr      <= 16'h0000;
      bus_dout      <= 8'h00;
      bus_doe       <= 1'b0;
      bus_rw        <= 1'b1;
      ram_cs_n      <= 1'b1;
      busy          <= 1'b0;
    end else begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            cur_req   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b1;
            cpu_rdy   <= 1'b0;
            busy      <= 1'b1;
            state     <= ST_STALL;
          end
        end
        // A read cycle ending with RDY low means the CPU is frozen in place.
        ST_STALL: begin
          if (phi2_fall && cpu_rw) begin
            phys_bus_en_n <= 1'b1;
            state         <= ST_ISOLATE;
          end else if (tmr_done) begin
            cpu_rdy   <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            state     <= ST_ABORT;
          end
        end
        ST_ABORT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        ST_ISOLATE: begin
          if (tmr_done) begin
            drive_bus_n <= 1'b0;
            bus_addr    <= cur_req.addr;
            bus_dout    <= cur_req.wdata;
            bus_rw      <= !cur_req.write;
            bus_doe     <= cur_req.write;
            state       <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            ram_cs_n <= 1'b0;
            state    <= ST_STROBE;
          end
        end
        ST_STROBE: begin
          if (tmr_done) begin
            if (!cur_req.write) begin
              rsp_rdata <= bus_din;
            end
            ram_cs_n  <= 1'b1;
            rsp_valid <= 1'b1;
            bus_doe   <= 1'b0;
            bus_rw    <= 1'b1;
            state     <= ST_DONE;
          end
        end
        // Back-to-back requests keep the bus and skip the guard/stall overhead.
        ST_DONE: begin
          if (req_valid) begin
            cur_req   <= '{write: req_write, addr: req_addr, wdata: req_wdata};
            req_ready <= 1'b1;
            bus_addr  <= req_addr;
            bus_dout  <= req_wdata;
            bus_rw    <= !req_write;
            bus_doe   <= req_write;
            state     <= ST_SETUP;
          end else begin
            drive_bus_n <= 1'b1;
            state       <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (tmr_done) begin
            phys_bus_en_n <= 1'b0;
            cpu_rdy       <= 1'b1;
            busy          <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assert property (@(posedge clk) disable iff (rst_p) (drive_bus_n || phys_bus_en_n));
  assert property (@(posedge clk) disable iff (rst_p) (ram_cs_n || !drive_bus_n));

endmodule
